stream_rr_arbiter: RTL
======================

# stream_rr_arbiter

Round-robin arbiter that shares one in-order val/rdy stream accelerator (the Adder) between two independent requesters, such as the Wishbone bridge and a second stream master. Accepted requests are tagged with their requester ID in a small tag FIFO. Each accelerator response is steered back to the requester at the FIFO head. The block sits between the requester-side streams and the accelerator's `i_stream`/`o_stream` ports, with no added latency on either path.

## Interface
- `DATA_W`, 32: stream payload width.
- `MAX_OUT`, 4: maximum outstanding requests inside the accelerator; power of two, ≥2; this is the tag FIFO depth.
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req0_val` in 1, `req0_data` in DATA_W, `req0_rdy` out 1: requester 0 request stream.
- `resp0_val` out 1, `resp0_data` out DATA_W, `resp0_rdy` in 1: requester 0 response stream.
- `req1_val` / `req1_data` / `req1_rdy`, `resp1_val` / `resp1_data` / `resp1_rdy`: requester 1, same definitions.
- `acc_i_val` out 1, `acc_i_data` out DATA_W, `acc_i_rdy` in 1: request stream to the accelerator.
- `acc_o_val` in 1, `acc_o_data` in DATA_W, `acc_o_rdy` out 1: response stream from the accelerator.
- `busy` out 1: high when the tag FIFO is non-empty.

## Operation
- A transfer fires on any stream when `val & rdy` are both high at a clock edge.
- Sources must hold `val` and `data` stable until the transfer fires.
- **Grant logic**
  - Grant is combinational, decided from a 1-bit priority pointer `prio`.
  - If only one requester is valid, that requester is granted.
  - If both are valid, requester `prio` is granted.
- **Request path**
  - `acc_i_val` = granted requester's `val` & ~`tag_full`.
  - `acc_i_data` = granted requester's data.
  - The granted requester's `rdy` = `acc_i_rdy` & ~`tag_full`.
  - The non-granted requester's `rdy` = 0.
- **On `acc_i` fire**
  - Push the granted ID into the tag FIFO.
  - Set `prio` to the other requester (round-robin).
  - If there is no fire, `prio` holds.
- **Response path**
  - `head` = ID at the FIFO head.
  - `resp[head]_val` = `acc_o_val` & ~`tag_empty`.
  - `resp[head]_data` = `acc_o_data`.
  - `acc_o_rdy` = `resp[head]_rdy` & ~`tag_empty`.
  - The other response port's `val` = 0.
  - On `acc_o` fire, pop the FIFO.
- **Boundary conditions**
  - Full: no push, even when a pop happens in the same cycle; both `req_rdy` = 0.
  - Empty: `acc_o_rdy` = 0 and both `resp_val` = 0. A response from the accelerator is held off, never dropped.
  - Push and pop in the same cycle (not full, not empty): occupancy unchanged, head advances.
  - FIFO pointers are log2(MAX_OUT)+1 bits and wrap modulo 2·MAX_OUT; full/empty are detected by MSB compare.
  - A requester blocked at its response port back-pressures the accelerator, which stalls both requesters. This is accepted by design.
- **Reset**
  - Mid-operation reset empties the FIFO and sets `prio` = 0.
  - Any in-flight accelerator responses must be flushed by the accelerator's own reset, which shares `reset`.

## Timing
- Request path and response path: 0-cycle combinational forward; the arbiter adds no latency.
- Reset values:
  - `busy` = 0, `acc_o_rdy` = 0, `resp0_val` = `resp1_val` = 0.
  - `prio` = 0.
  - `acc_i_val` and `req*_rdy` follow inputs; with the FIFO empty after reset they are not gated.
- Sustained throughput: one request per cycle when `acc_i_rdy` = 1.
- Under continuous contention, grants alternate 0,1,0,1 starting with 0 after reset.
- No combinational loop: `acc_i_val` does not depend on `acc_i_rdy`, and `resp_val` does not depend on `resp_rdy`.

## Configuration
- `ARB_GRANT_CNT_EN` defined:
  - Adds output ports `grant_cnt0` and `grant_cnt1` (16 bits each).
  - Each counter increments on every `acc_i` fire for its requester.
  - Counters wrap 0xFFFF→0 and reset to 0.
- `ARB_GRANT_CNT_EN` undefined: the ports and counters are absent, with no other behavioural difference.

## Structure
- Shared package `stream_arb_pkg` holds:
  - `REQ_ID_W` = 1.
  - Typedef `req_id_t`.
  - Constant `GRANT_CNT_W` = 16.
- One sub-module, `arb_tag_fifo`:
  - Synchronous FIFO of `req_id_t`, depth `MAX_OUT`.
  - Ports: push, pop, din, dout, full, empty.
  - Registered storage; dout is a combinational head read.

## Test plan
- Bench model of the accelerator: returns data+1, latency 3 cycles, in order.
- Single requester: req0 sends 0x10, 0x20 → resp0 returns 0x11, 0x21 in order; resp1_val never asserts; busy drops to 0 afterwards.
- Contention: both requesters valid from reset with streams (0xA0..) and (0xB0..) → `acc_i_data` order A0,B0,A1,B1; resp0 receives only A*+1 and resp1 receives only B*+1.
- Full: `acc_i_rdy` = 1 while the model withholds responses, MAX_OUT=4 → exactly 4 accepted; both `req_rdy` = 0 until the first response pops; a push in the same cycle as that pop is refused.
- Response back-pressure: hold `resp1_rdy` = 0 while resp1 is at the head → `acc_o_rdy` = 0 and resp0 stalls; release `resp1_rdy` → both drain in order with no loss.
- Reset mid-operation: assert `reset` with 3 outstanding → next cycle `busy` = 0 and `prio` = 0; next contention grants req0 first.
- `ARB_GRANT_CNT_EN`: 5 grants to req0 and 3 to req1 → `grant_cnt0` = 5, `grant_cnt1` = 3; preloaded 0xFFFF plus one grant → 0.

Source files
------------

// File: rtl/stream_arb_pkg.sv
// Shared types and constants for the two-requester stream arbiter.
package stream_arb_pkg;

  localparam int REQ_ID_W    = 1;
  localparam int GRANT_CNT_W = 16;

  typedef logic [REQ_ID_W-1:0] req_id_t;

  // With two requesters the round-robin successor is simply the other ID.
  function automatic req_id_t other_id(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// Tag FIFO holding the requester ID of every request in flight inside the accelerator.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module arb_tag_fifo
  import stream_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  logic    pop,
  input  req_id_t din,
  output req_id_t dout,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  req_id_t     mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is data, not control: no reset needed, empty masks stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin sharing of one in-order val/rdy accelerator between two requesters.
// Optional per-requester grant counters are built when ARB_GRANT_CNT_EN is defined.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_val,
  input  logic [DATA_W-1:0]      req0_data,
  output logic                   req0_rdy,
  output logic                   resp0_val,
  output logic [DATA_W-1:0]      resp0_data,
  input  logic                   resp0_rdy,
  input  logic                   req1_val,
  input  logic [DATA_W-1:0]      req1_data,
  output logic                   req1_rdy,
  output logic                   resp1_val,
  output logic [DATA_W-1:0]      resp1_data,
  input  logic                   resp1_rdy,
  output logic                   acc_i_val,
  output logic [DATA_W-1:0]      acc_i_data,
  input  logic                   acc_i_rdy,
  input  logic                   acc_o_val,
  input  logic [DATA_W-1:0]      acc_o_data,
  output logic                   acc_o_rdy,
  output logic                   busy
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [GRANT_CNT_W-1:0] grant_cnt0,
  output logic [GRANT_CNT_W-1:0] grant_cnt1
`endif
);

  req_id_t prio;
  req_id_t grant_id;
  req_id_t head_id;
  logic    tag_full;
  logic    tag_empty;
  logic    acc_i_fire;
  logic    acc_o_fire;

  // Grant only looks at val and prio, so acc_i_val never depends on acc_i_rdy.
  always_comb begin
    grant_id = prio;
    if (req0_val && !req1_val)      grant_id = req_id_t'(0);
    else if (req1_val && !req0_val) grant_id = req_id_t'(1);
  end

  always_comb begin
    acc_i_val  = 1'b0;
    acc_i_data = req0_data;
    req0_rdy   = 1'b0;
    req1_rdy   = 1'b0;
    if (grant_id == req_id_t'(0)) begin
      acc_i_val = req0_val & ~tag_full;
      req0_rdy  = acc_i_rdy & ~tag_full;
    end else begin
      acc_i_val  = req1_val & ~tag_full;
      acc_i_data = req1_data;
      req1_rdy   = acc_i_rdy & ~tag_full;
    end
  end

  assign acc_i_fire = acc_i_val & acc_i_rdy;

  always_ff @(posedge clk) begin
    if (reset)           prio <= req_id_t'(0);
    else if (acc_i_fire) prio <= other_id(grant_id);
  end

  // Responses return in request order, so the FIFO head names the owner.
  always_comb begin
    resp0_val  = 1'b0;
    resp1_val  = 1'b0;
    resp0_data = acc_o_data;
    resp1_data = acc_o_data;
    acc_o_rdy  = 1'b0;
    if (!tag_empty) begin
      if (head_id == req_id_t'(0)) begin
        resp0_val = acc_o_val;
        acc_o_rdy = resp0_rdy;
      end else begin
        resp1_val = acc_o_val;
        acc_o_rdy = resp1_rdy;
      end
    end
  end

  assign acc_o_fire = acc_o_val & acc_o_rdy;
  assign busy       = ~tag_empty;

  arb_tag_fifo #(
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (acc_i_fire),
    .pop   (acc_o_fire),
    .din   (grant_id),
    .dout  (head_id),
    .full  (tag_full),
    .empty (tag_empty)
  );

`ifdef ARB_GRANT_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (acc_i_fire) begin
      if (grant_id == req_id_t'(0)) grant_cnt0 <= grant_cnt0 + GRANT_CNT_W'(1);
      else                          grant_cnt1 <= grant_cnt1 + GRANT_CNT_W'(1);
    end
  end
`endif

endmodule
